// File: rtl/button_event_decoder_pkg.sv
// Shared types and helpers for the button event decoder.
package button_event_decoder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_GAP    = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_event_decoder_edge_det.sv
// Registers an already-synchronous level and flags its rising and falling edges.
module btn_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din_i,
    output logic rise_o,
    output logic fall_o
);

    logic din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din_i;
        end
    end

    assign rise_o = din_i & ~din_q;
    assign fall_o = ~din_i & din_q;

endmodule

// File: rtl/button_event_decoder.sv
// Classifies a debounced button level into press/release/short/double/long/repeat pulses.
//
//  state     | meaning
//  ----------+-----------------------------------------------
//  ST_IDLE   | no gesture in progress
//  ST_PRESS1 | first press held, timing toward long press
//  ST_GAP    | short press released, waiting for a second press
//  ST_PRESS2 | second press held, double click if released early
//  ST_LONG   | long press held, issuing auto-repeat
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int LONG_TICKS   = 1000,
    parameter int GAP_TICKS    = 300,
    parameter int REPEAT_TICKS = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_db,
    output logic press_p,
    output logic release_p,
    output logic short_p,
    output logic double_p,
    output logic long_p,
    output logic repeat_p,
    output logic busy
);

    localparam int CNT_W = $clog2(max3(LONG_TICKS, GAP_TICKS, REPEAT_TICKS) + 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_TICKS - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'((REPEAT_TICKS == 0) ? 0 : REPEAT_TICKS - 1);

    logic             rise;
    logic             fall;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             press_q, release_q, short_q, double_q, long_q, repeat_q;

    btn_edge_det u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (btn_db),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Saturating increment; thresholds normally restart the count before the top.
    assign cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            press_q   <= rise;
            release_q <= fall;
            short_q   <= 1'b0;
            double_q  <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rise) begin
                        state_q <= ST_PRESS1;
                        cnt_q   <= '0;
                    end
                end
                ST_PRESS1, ST_PRESS2: begin
                    // A release on the threshold edge still counts as a short press.
                    if (fall) begin
                        cnt_q <= '0;
                        if (state_q == ST_PRESS1) begin
                            state_q <= ST_GAP;
                        end else begin
                            state_q  <= ST_IDLE;
                            double_q <= 1'b1;
                        end
                    end else if (cnt_q == LONG_LAST) begin
                        state_q <= ST_LONG;
                        long_q  <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_GAP: begin
                    if (rise) begin
                        state_q <= ST_PRESS2;
                        cnt_q   <= '0;
                    end else if (cnt_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                        short_q <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                ST_LONG: begin
                    if (fall) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end else if (REPEAT_TICKS != 0) begin
                        if (cnt_q == REP_LAST) begin
                            repeat_q <= 1'b1;
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign press_p   = press_q;
    assign release_p = release_q;
    assign short_p   = short_q;
    assign double_p  = double_q;
    assign long_p    = long_q;
    assign repeat_p  = repeat_q;
    assign busy      = (state_q != ST_IDLE);

endmodule
